pipe_skid_reg: RTL and testbench

Parametrised pipeline register with valid/ready handshake, a one-entry skid buffer, and synchronous flush. It generalises the plain enable/clear pipeline flops into a back-pressure-aware stage. It sits between pipeline stages of the core (e.g. IF/ID, ID/EX) so that stall and flush are expressed as handshakes. It sustains one transfer per cycle, and every stage-to-stage control path is registered.

---
 rtl/pipe_skid_reg_pkg.sv | 27 ++
 rtl/pipe_skid_reg_flopenclr.sv | 24 ++
 rtl/pipe_skid_reg.sv | 130 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: stage state encoding, occupancy width and the
// default payload width for a 32-bit core.
package pipe_skid_reg_pkg;

    localparam int XLEN          = 32;
    localparam int DEFAULT_WIDTH = XLEN;
    localparam int OCC_W         = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // Entries held in each state; the unused encoding reads as empty.
    function automatic logic [OCC_W-1:0] occ_of(input state_t s);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (s)
            FULL:    occ = 2'd1;
            SKID:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_flopenclr.sv
// Enable flop with synchronous clear and asynchronous active-low reset to zero.
// Clear wins over enable.
module flopenclr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Back-pressure-aware pipeline stage: registered valid/ready handshake with a
// one-entry skid buffer and synchronous flush.
//
// state | meaning
// EMPTY | nothing held; in_ready=1, out_valid=0
// FULL  | main holds one entry; in_ready=1, out_valid=1
// SKID  | main and skid both hold entries; in_ready=0, out_valid=1
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             send;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign accept   = in_valid & in_ready;
    assign send     = out_valid & out_ready;
    assign out_data = main_q;

    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_en   = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (accept && send) begin
                        main_en = 1'b1;
                    end else if (send) begin
                        state_nxt = EMPTY;
                    end else if (accept) begin
                        skid_en   = 1'b1;
                        state_nxt = SKID;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only the drain path exists.
                    if (send) begin
                        main_en   = 1'b1;
                        main_d    = skid_q;
                        state_nxt = FULL;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state, so out_ready has
    // no combinational path to in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != SKID);
            out_valid <= (state_nxt != EMPTY);
            occupancy <= occ_of(state_nxt);
        end
    end

    generate
        if (RESET_DATA == '0) begin : g_flop_zero
            flopenclr #(.WIDTH(WIDTH)) u_main (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (main_en),
                .clr   (flush),
                .d     (main_d),
                .q     (main_q)
            );
            flopenclr #(.WIDTH(WIDTH)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (skid_en),
                .clr   (flush),
                .d     (in_data),
                .q     (skid_q)
            );
        end else begin : g_flop_const
            // The shared primitive only clears to zero, so a non-zero reset
            // value needs local registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q <= RESET_DATA;
                    skid_q <= RESET_DATA;
                end else if (flush) begin
                    main_q <= RESET_DATA;
                    skid_q <= RESET_DATA;
                end else begin
                    if (main_en) main_q <= main_d;
                    if (skid_en) skid_q <= in_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // Model: FIFO of held entries (capacity 2) and the last value in main.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;

    pipe_skid_reg #(.WIDTH(W), .RESET_DATA('0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = '0;
    endtask

    // Apply one cycle of inputs; the model advances with the clock edge and
    // the task returns at the following falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        bit acc;
        bit snd;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        acc = v && (mq.size() < 2);
        snd = r && (mq.size() > 0);
        @(posedge clk);
        if (f) begin
            model_reset();
        end else begin
            if (snd) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            if (mq.size() > 0) m_last = mq[0];
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check("model in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
            check("model out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            check("model occupancy", {30'd0, occupancy}, mq.size());
            check("model out_data",  out_data,           m_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset in_ready",  {31'd0, in_ready},  32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset occupancy", {30'd0, occupancy}, 32'd0);
        check("reset out_data",  out_data,           32'd0);
        check_en = 1;

        // Streaming at full rate
        step(1, 32'h11, 1, 0);
        check("stream d0", out_data, 32'h11);
        step(1, 32'h22, 1, 0);
        check("stream d1", out_data, 32'h22);
        check("stream occ", {30'd0, occupancy}, 32'd1);
        step(1, 32'h33, 1, 0);
        check("stream d2", out_data, 32'h33);
        step(0, 32'h0, 1, 0);
        check("drain valid", {31'd0, out_valid}, 32'd0);
        check("drain data held", out_data, 32'h33);

        // Stall into the skid, then drain in order
        step(1, 32'hA0, 0, 0);
        step(1, 32'hB0, 0, 0);
        check("skid occ", {30'd0, occupancy}, 32'd2);
        check("skid in_ready", {31'd0, in_ready}, 32'd0);
        check("skid head", out_data, 32'hA0);
        step(1, 32'hC0, 0, 0);
        check("skid stalled head", out_data, 32'hA0);
        step(0, 32'h0, 1, 0);
        check("skid drain1", out_data, 32'hB0);
        check("skid drain1 occ", {30'd0, occupancy}, 32'd1);
        step(0, 32'h0, 1, 0);
        check("skid drain2 valid", {31'd0, out_valid}, 32'd0);

        // Accept and send together in FULL
        step(1, 32'h55, 0, 0);
        step(1, 32'h66, 1, 0);
        check("acc+send data", out_data, 32'h66);
        check("acc+send occ", {30'd0, occupancy}, 32'd1);

        // Flush dominates accept and send
        step(1, 32'h77, 0, 0);
        check("pre-flush occ", {30'd0, occupancy}, 32'd2);
        step(1, 32'h88, 1, 1);
        check("flush occ", {30'd0, occupancy}, 32'd0);
        check("flush valid", {31'd0, out_valid}, 32'd0);
        check("flush data", out_data, 32'd0);
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        step(0, 32'h0, 1, 0);
        check("post-flush valid", {31'd0, out_valid}, 32'd0);

        // Mixed handshake patterns, checked by the model every cycle
        for (int i = 0; i < 48; i++) begin
            step((i % 3) != 2, 32'h100 + i, ((i % 5) == 0) || ((i % 5) == 3) || (i > 36), (i == 20));
        end

        // Asynchronous reset between edges while FULL
        step(0, 32'h0, 1, 0);
        step(1, 32'h99, 0, 0);
        check("pre-reset valid", {31'd0, out_valid}, 32'd1);
        check_en = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async valid", {31'd0, out_valid}, 32'd0);
        check("async occ", {30'd0, occupancy}, 32'd0);
        check("async data", out_data, 32'd0);
        check("async in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1;
        step(1, 32'h5A, 1, 0);
        check("after reset data", out_data, 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
